meal_server: RTL
================

Name: meal_server

Overview:
- Shared-kitchen controller that serves one meal at a time to N kid FSMs.
- Each kid drives its request line while hungry; this block arbitrates round-robin, runs a fixed cook delay, then pulses the winner's meal input for one cycle.
- Tracks a finite serving stock that is refilled by a restock pulse.
- Sits between the kid instances and the top level; kid.request feeds request[i], and meal[i] feeds kid.meal.

Parameters:
- N_KIDS, 4: number of requesters; must be ≥ 2.
- COOK_CYCLES, 3: cycles spent in COOK per meal; must be ≥ 1.
- MAX_SERVINGS, 8: stock value loaded on reset and on restock; must be ≥ 1.

Ports:
- clk  input  1: rising-edge clock.
- resetb  input  1: synchronous, active-low reset.
- request  input  N_KIDS: bit i high means kid i wants a meal; level-sensitive.
- restock  input  1: single-cycle pulse; reload stock to MAX_SERVINGS.
- meal  output  N_KIDS: one-hot pulse to the served kid; registered.
- grant_id  output  $clog2(N_KIDS): index of the kid being served or cooked for.
- busy  output  1: high when state is not IDLE.
- stock  output  $clog2(MAX_SERVINGS+1): servings remaining.
- empty  output  1: high when stock == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetb; it is sampled only at the rising edge of clk.
- Reset values: state = IDLE; meal = 0; grant_id = 0; busy = 0; stock = MAX_SERVINGS; empty = 0; cook counter = 0; rr_ptr = N_KIDS-1, so kid 0 has first priority.
- Reset mid-operation: any in-flight meal is dropped, no meal pulse is issued, and stock is reloaded.
- State encoding: IDLE, COOK, SERVE, encoded in 2 bits.
- IDLE:
  - If request != 0 and stock != 0, select the first set request bit scanning from rr_ptr+1 upward with wrap-around.
  - Latch that index into grant_id, load the counter with COOK_CYCLES-1, and go to COOK.
  - Otherwise stay in IDLE; grant_id holds its last value.
- COOK:
  - If counter == 0, go to SERVE; otherwise decrement the counter.
  - COOK always lasts exactly COOK_CYCLES cycles.
  - request is ignored during COOK. A granted kid that drops its request still receives its meal, because a grant is committed.
- SERVE:
  - Lasts one cycle. meal[grant_id] = 1; all other meal bits = 0.
  - In the same cycle: stock decrements by 1, rr_ptr <= grant_id, and the next state is IDLE.
- meal outputs: meal is 0 in every state other than SERVE.
- Latency: request sampled in IDLE at clock edge E → meal high during cycle E+COOK_CYCLES+1 (4 cycles for the default). The minimum spacing between meal pulses is COOK_CYCLES+2 cycles.
- Stock behaviour:
  - Stock never goes below 0.
  - When stock == 0, IDLE does not grant, empty = 1, and requests wait.
  - restock sets stock = MAX_SERVINGS in any state.
  - restock coinciding with a SERVE decrement: restock wins, and stock = MAX_SERVINGS.
  - restock while empty in IDLE: a grant becomes possible on the following cycle, since the grant decision uses the registered stock.
- Simultaneous requests: exactly one grant per arbitration. A requester is never starved; any continuously requesting kid is served within N_KIDS grants.
- busy: busy = (state != IDLE).
- Output timing: all outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

Test Plan (defaults N_KIDS=4, COOK_CYCLES=3, MAX_SERVINGS=8):
- Reset, then request=4'b0010 held one cycle → grant_id=1, busy high for 4 cycles, meal=4'b0010 exactly once 4 cycles after sampling, stock=7.
- request=4'b1111 held continuously → meal order is kid 0,1,2,3,0,1,2,3; pulses are 5 cycles apart; after 8 meals, stock=0, empty=1, and no further meal pulses occur.
- While empty with requests pending, pulse restock → stock=8, empty=0; the next grant occurs on the following cycle in round-robin order.
- Kid 2 requests and then drops request during COOK → meal=4'b0100 is still delivered and stock decrements.
- Assert restock in the same cycle as SERVE with stock=5 → stock=8, not 4; the meal is still delivered.
- Assert resetb=0 for one cycle during COOK → no meal pulse, state=IDLE, stock=8, and kid 0 has first priority again.

Source files
------------

// File: rtl/meal_server.sv
// Shared-kitchen controller: round-robin arbitration among N_KIDS requesters,
// a fixed cook delay, a one-cycle meal pulse to the winner, and a restockable serving count.
module meal_server #(
    parameter  int N_KIDS       = 4,
    parameter  int COOK_CYCLES  = 3,
    parameter  int MAX_SERVINGS = 8,
    localparam int GW           = $clog2(N_KIDS),
    localparam int SW           = $clog2(MAX_SERVINGS + 1),
    localparam int CW           = (COOK_CYCLES > 1) ? $clog2(COOK_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [N_KIDS-1:0] request,
    input  logic              restock,
    output logic [N_KIDS-1:0] meal,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic [SW-1:0]     stock,
    output logic              empty
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COOK  = 2'd1,
        S_SERVE = 2'd2
    } state_e;

    localparam logic [CW-1:0] COOK_LOAD  = CW'(COOK_CYCLES - 1);
    localparam logic [SW-1:0] STOCK_FULL = SW'(MAX_SERVINGS);
    localparam logic [GW-1:0] RR_INIT    = GW'(N_KIDS - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]     stock_q, stock_d;
    logic [N_KIDS-1:0] meal_q, meal_d;

    logic              pick_valid;
    logic [GW-1:0]     pick_id;

    // Round-robin scan: the kid just after the last one served has top priority.
    always_comb begin
        int scan_idx;
        pick_valid = 1'b0;
        pick_id    = '0;
        scan_idx   = 0;
        for (int i = 1; i <= N_KIDS; i++) begin
            scan_idx = (int'(rr_ptr_q) + i) % N_KIDS;
            if (!pick_valid && request[GW'(scan_idx)]) begin
                pick_valid = 1'b1;
                pick_id    = GW'(scan_idx);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        stock_d  = stock_q;
        meal_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_valid && (stock_q != '0)) begin
                    grant_d = pick_id;
                    cnt_d   = COOK_LOAD;
                    state_d = S_COOK;
                end
            end
            S_COOK: begin
                if (cnt_q == '0) begin
                    state_d         = S_SERVE;
                    meal_d[grant_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SERVE: begin
                state_d  = S_IDLE;
                rr_ptr_d = grant_q;
                if (stock_q != '0) begin
                    stock_d = stock_q - SW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A restock overrides any decrement taken in the same cycle.
        if (restock) begin
            stock_d = STOCK_FULL;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            rr_ptr_q <= RR_INIT;
            stock_q  <= STOCK_FULL;
            meal_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            stock_q  <= stock_d;
            meal_q   <= meal_d;
        end
    end

    assign meal     = meal_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);
    assign stock    = stock_q;
    assign empty    = (stock_q == '0);

endmodule
